// File: rtl/fifo_data_buffer_pkg.sv
// Purpose: shared constants and serializer state encoding for the byte-to-dibit buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_data_buffer_pkg;

    localparam int DEFAULT_DEPTH   = 128;
    localparam int DIBITS_PER_BYTE = 4;
    localparam int DIBIT_IDX_W     = $clog2(DIBITS_PER_BYTE);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/fifo_data_buffer_byte_fifo.sv
// Purpose: byte FIFO with show-ahead head output (dout is the oldest stored byte).
// Latency: a byte pushed at edge k is visible on dout / clears empty after edge k.
// Backpressure: none upstream; a push while full is dropped, a pop while empty is ignored.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   push, din      write request and byte
//   pop            consume the head byte
//   dout           head byte (valid while !empty)
//   empty, full    occupancy flags from the registered count
//   count          number of stored bytes, 0..DEPTH
module byte_fifo
    import fifo_data_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full  = (count_q == DEPTH_CNT);
        empty = (count_q == '0);
        // Fullness is judged on the registered count, so a pop on the same
        // edge does not make room for a push that arrives while full.
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
        dout     = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/fifo_data_buffer.sv
// Purpose: buffer incoming bytes and serialize each as 4 dibits, LSB dibit first.
// Latency: byte written into an empty buffer at edge k gives its first dibit after edge k+1.
// Backpressure: none; bytes arriving while the buffer is full are dropped silently.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   valid_in        byte_in carries a byte this cycle
//   byte_in         input byte
//   axiov           axiod carries a dibit this cycle (registered)
//   axiod           output dibit, forced to 00 whenever axiov is low (registered)
module fifo_data_buffer
    import fifo_data_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] byte_in,
    output logic       axiov,
    output logic [1:0] axiod
);

    localparam logic [DIBIT_IDX_W-1:0] LAST_IDX = DIBIT_IDX_W'(DIBITS_PER_BYTE - 1);

    ser_state_e             state_q, state_d;
    logic [DIBIT_IDX_W-1:0] idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   axiov_q, axiov_d;
    logic [1:0]             axiod_q, axiod_d;

    logic                   fifo_pop;
    logic [7:0]             fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_status_unused;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_byte_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (valid_in),
        .din   (byte_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // The serializer only needs the empty flag and the head byte.
    assign fifo_status_unused = ^{fifo_full, fifo_count};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        axiov_d  = axiov_q;
        axiod_d  = axiod_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            IDLE: begin
                axiov_d = 1'b0;
                axiod_d = 2'b00;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    axiov_d  = 1'b1;
                    axiod_d  = fifo_dout[1:0];
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    if (!fifo_empty) begin
                        // Back-to-back load keeps axiov high across bytes.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        axiov_d  = 1'b1;
                        axiod_d  = fifo_dout[1:0];
                        idx_d    = '0;
                    end else begin
                        axiov_d = 1'b0;
                        axiod_d = 2'b00;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    // shift_q holds the dibit on the wire in [1:0]; the next one sits in [3:2].
                    axiod_d = shift_q[3:2];
                    shift_d = {2'b00, shift_q[7:2]};
                    idx_d   = idx_q + DIBIT_IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                axiov_d = 1'b0;
                axiod_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
        end
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule

// File: tb/tb_fifo_data_buffer.sv
// Purpose: self-checking bench for fifo_data_buffer (default depth and depth 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_data_buffer;

    logic       clk;
    logic       rst;
    logic       vld_a, vld_b;
    logic [7:0] byte_a, byte_b;
    logic       axiov_a, axiov_b;
    logic [1:0] axiod_a, axiod_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [1:0] sb_a [$];
    logic [1:0] sb_b [$];
    logic [1:0] e_a, e_b;
    bit         mon_en = 0;

    int vcnt_a = 0, first_a = -1, last_a = -1;
    int vcnt_b = 0;

    fifo_data_buffer u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .valid_in (vld_a),
        .byte_in  (byte_a),
        .axiov    (axiov_a),
        .axiod    (axiod_a)
    );

    fifo_data_buffer #(.DEPTH(4)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .valid_in (vld_b),
        .byte_in  (byte_b),
        .axiov    (axiov_b),
        .axiod    (axiod_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: pop the scoreboard on every valid dibit.
    always @(negedge clk) begin
        if (rst === 1'b1 && mon_en) begin
            if (axiov_a === 1'b1) begin
                checks++;
                assert (sb_a.size() > 0) else begin
                    errors++;
                    $error("FAIL a_unexpected_dibit observed=%0d expected=none", axiod_a);
                end
                if (sb_a.size() > 0) begin
                    e_a = sb_a.pop_front();
                    checks++;
                    assert (axiod_a === e_a) else begin
                        errors++;
                        $error("FAIL a_dibit observed=%0d expected=%0d", axiod_a, e_a);
                    end
                end
                if (first_a < 0) first_a = cyc;
                last_a = cyc;
                vcnt_a++;
            end else begin
                checks++;
                assert (axiod_a === 2'b00) else begin
                    errors++;
                    $error("FAIL a_idle_dibit observed=%0d expected=0", axiod_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && mon_en) begin
            if (axiov_b === 1'b1) begin
                checks++;
                assert (sb_b.size() > 0) else begin
                    errors++;
                    $error("FAIL b_unexpected_dibit observed=%0d expected=none", axiod_b);
                end
                if (sb_b.size() > 0) begin
                    e_b = sb_b.pop_front();
                    checks++;
                    assert (axiod_b === e_b) else begin
                        errors++;
                        $error("FAIL b_dibit observed=%0d expected=%0d", axiod_b, e_b);
                    end
                end
                vcnt_b++;
            end else begin
                checks++;
                assert (axiod_b === 2'b00) else begin
                    errors++;
                    $error("FAIL b_idle_dibit observed=%0d expected=0", axiod_b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic exp_byte_a(input logic [7:0] b);
        sb_a.push_back(b[1:0]);
        sb_a.push_back(b[3:2]);
        sb_a.push_back(b[5:4]);
        sb_a.push_back(b[7:6]);
    endtask

    task automatic exp_byte_b(input logic [7:0] b);
        sb_b.push_back(b[1:0]);
        sb_b.push_back(b[3:2]);
        sb_b.push_back(b[5:4]);
        sb_b.push_back(b[7:6]);
    endtask

    task automatic stats_clear();
        vcnt_a  = 0;
        first_a = -1;
        last_a  = -1;
        vcnt_b  = 0;
    endtask

    // Returns at negedge+1 of the cycle in which the last expected dibit was seen.
    task automatic wait_drain_a(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sb_a.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk(tag, sb_a.size(), 0);
    endtask

    task automatic wait_drain_b(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sb_b.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk(tag, sb_b.size(), 0);
    endtask

    logic [7:0] acc_b [9];

    initial begin
        rst = 1'b1; vld_a = 1'b0; byte_a = 8'h00; vld_b = 1'b0; byte_b = 8'h00;

        // Reset state, held low for one cycle.
        #2 rst = 1'b0;
        #1;
        chk("rst_axiov_a", axiov_a, 0);
        chk("rst_axiod_a", axiod_a, 0);
        chk("rst_axiov_b", axiov_b, 0);
        chk("rst_axiod_b", axiod_b, 0);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1;
        stats_clear();
        repeat (10) @(negedge clk);
        #1;
        chk("idle_no_output", vcnt_a + vcnt_b, 0);

        // Single 0xD2: latency and dibit order 2,0,1,3.
        stats_clear();
        @(negedge clk);
        vld_a = 1'b1; byte_a = 8'hD2;
        sb_a.push_back(2'd2); sb_a.push_back(2'd0); sb_a.push_back(2'd1); sb_a.push_back(2'd3);
        @(negedge clk);
        vld_a = 1'b0;
        #1 chk("lat_not_yet", axiov_a, 0);
        @(negedge clk);
        #1 chk("lat_first_dibit", {axiov_a, axiod_a}, 3'b110);
        repeat (4) @(negedge clk);
        #1 chk("single_tail_low", axiov_a, 0);
        chk("single_cnt", vcnt_a, 4);
        chk("single_sb_empty", sb_a.size(), 0);

        // 0x1B, 0xE4 back-to-back: 3,2,1,0,0,1,2,3 contiguous.
        stats_clear();
        @(negedge clk); vld_a = 1'b1; byte_a = 8'h1B;
        @(negedge clk); vld_a = 1'b1; byte_a = 8'hE4;
        foreach (sb_a[i]) ; // keep queue as-is
        sb_a.push_back(2'd3); sb_a.push_back(2'd2); sb_a.push_back(2'd1); sb_a.push_back(2'd0);
        sb_a.push_back(2'd0); sb_a.push_back(2'd1); sb_a.push_back(2'd2); sb_a.push_back(2'd3);
        @(negedge clk); vld_a = 1'b0;
        wait_drain_a(40, "pair_drain");
        @(negedge clk);
        #1 chk("pair_tail_low", axiov_a, 0);
        chk("pair_cnt", vcnt_a, 8);
        chk("pair_contig", last_a - first_a + 1, 8);

        // 84 consecutive 0xD2 bytes: 336 contiguous dibits, no overflow.
        stats_clear();
        for (int i = 0; i < 84; i++) begin
            @(negedge clk);
            vld_a = 1'b1; byte_a = 8'hD2;
            exp_byte_a(8'hD2);
        end
        @(negedge clk); vld_a = 1'b0;
        wait_drain_a(600, "burst_drain");
        @(negedge clk);
        #1 chk("burst_tail_low", axiov_a, 0);
        chk("burst_cnt", vcnt_a, 336);
        chk("burst_contig", last_a - first_a + 1, 336);

        // Reset during the second dibit of 0xB4 with more bytes buffered.
        @(negedge clk); vld_a = 1'b1; byte_a = 8'hB4;
        @(negedge clk); vld_a = 1'b1; byte_a = 8'h3C;
        @(negedge clk); vld_a = 1'b1; byte_a = 8'h77;
        exp_byte_a(8'hB4);
        @(negedge clk); vld_a = 1'b0;
        #1 chk("mid_second_dibit", {axiov_a, axiod_a}, 3'b101);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_axiov", axiov_a, 0);
        chk("async_rst_axiod", axiod_a, 0);
        sb_a.delete();
        vld_a = 1'b1; byte_a = 8'hFF;   // must be ignored while in reset
        @(negedge clk);
        vld_a = 1'b0;
        rst = 1'b1;
        stats_clear();
        repeat (8) @(negedge clk);
        #1 chk("post_rst_empty", vcnt_a, 0);
        stats_clear();
        @(negedge clk); vld_a = 1'b1; byte_a = 8'h9C;
        sb_a.push_back(2'd0); sb_a.push_back(2'd3); sb_a.push_back(2'd1); sb_a.push_back(2'd2);
        @(negedge clk); vld_a = 1'b0;
        @(negedge clk);
        #1 chk("post_rst_first", {axiov_a, axiod_a}, 3'b100);
        wait_drain_a(40, "post_rst_drain");
        @(negedge clk);
        #1 chk("post_rst_cnt", vcnt_a, 4);

        // DEPTH=4, 20 back-to-back writes 0x00..0x13: only accepted bytes appear.
        acc_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h0A, 8'h0E, 8'h12};
        foreach (acc_b[i]) exp_byte_b(acc_b[i]);
        stats_clear();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vld_b = 1'b1; byte_b = 8'(i);
        end
        @(negedge clk); vld_b = 1'b0;
        wait_drain_b(200, "ovf_drain");
        @(negedge clk);
        #1 chk("ovf_tail_low", axiov_b, 0);
        chk("ovf_cnt", vcnt_b, 36);
        chk("ovf_a_quiet", vcnt_a, 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
